spawn_path: RTL and testbench

SPAWN_PATH -- requirements
Module: spawn_path

---
 rtl/spawn_path_if.sv | 25 ++
 rtl/spawn_path.sv | 207 ++++++++++++++++++++
 tb/tb_spawn_path.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spawn_path_if.sv
// Load bus for spawn_path: one request selects a channel and carries a new
// source/destination pair plus the log2 step count.
interface spawn_path_if #(
    parameter int HWIDTH = 11,
    parameter int VWIDTH = 10,
    parameter int NCH    = 4,
    parameter int LMAX   = 7
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = (LMAX > 0) ? $clog2(LMAX + 1) : 1;

    logic                     ld_valid;
    logic [CW-1:0]            ld_ch;
    logic signed [HWIDTH-1:0] ld_hsrc;
    logic signed [HWIDTH-1:0] ld_hdst;
    logic signed [VWIDTH-1:0] ld_vsrc;
    logic signed [VWIDTH-1:0] ld_vdst;
    logic [LW-1:0]            ld_lsteps;
    logic                     ld_ready;

    modport master (output ld_valid, ld_ch, ld_hsrc, ld_hdst, ld_vsrc, ld_vdst, ld_lsteps,
                    input  ld_ready);
    modport slave  (input  ld_valid, ld_ch, ld_hsrc, ld_hdst, ld_vsrc, ld_vdst, ld_lsteps,
                    output ld_ready);
endinterface

// File: rtl/spawn_path.sv
// spawn_path: NCH independent channels, each walking an offset from src to dst
// in 2^L equal ticks using a floor-divided accumulator per axis.
// Optional feature macro SPAWN_HOLD_EN: after completion a channel holds dst
// until ack instead of falling straight back to src.

module spawn_path_ch #(
    parameter int HWIDTH = 11,
    parameter int VWIDTH = 10,
    parameter int LMAX   = 7,
    parameter int LW     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_en,
    input  logic signed [HWIDTH-1:0] ld_hsrc,
    input  logic signed [HWIDTH-1:0] ld_hdst,
    input  logic signed [VWIDTH-1:0] ld_vsrc,
    input  logic signed [VWIDTH-1:0] ld_vdst,
    input  logic [LW-1:0]            ld_l,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     ack,
    output logic signed [HWIDTH-1:0] hoff,
    output logic signed [VWIDTH-1:0] voff,
    output logic                     active,
    output logic                     done
);
    localparam int DH = HWIDTH + 1;
    localparam int DV = VWIDTH + 1;
    localparam int AH = DH + LMAX;
    localparam int AV = DV + LMAX;
    localparam int KW = LMAX + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;

    logic hold_ack;
`ifdef SPAWN_HOLD_EN
    localparam state_t DONE_ST = S_HOLD;
    assign hold_ack = ack;
`else
    localparam state_t DONE_ST = S_IDLE;
    logic unused_ack;
    assign unused_ack = ack;
    assign hold_ack   = 1'b0;
`endif

    state_t state_q, state_d;
    logic signed [HWIDTH-1:0] hsrc_q, hsrc_d, hdst_q, hdst_d, hoff_q, hoff_d;
    logic signed [VWIDTH-1:0] vsrc_q, vsrc_d, vdst_q, vdst_d, voff_q, voff_d;
    logic [LW-1:0]            l_q, l_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [AH-1:0]     hacc_q, hacc_d, hsum, hstep;
    logic signed [AV-1:0]     vacc_q, vacc_d, vsum, vstep;
    logic signed [DH-1:0]     hdelta;
    logic signed [DV-1:0]     vdelta;
    logic                     done_q, done_d;
    logic                     last;

    // Per-axis delta, next accumulator, scaled step and final-tick detect
    always_comb begin
        hdelta = DH'(hdst_q) - DH'(hsrc_q);
        vdelta = DV'(vdst_q) - DV'(vsrc_q);
        hsum   = hacc_q + AH'(hdelta);
        vsum   = vacc_q + AV'(vdelta);
        hstep  = hsum >>> l_q;
        vstep  = vsum >>> l_q;
        last   = (k_q + KW'(1)) == (KW'(1) << l_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (tick && last) state_d = DONE_ST;
            S_HOLD:  if (ld_en || hold_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: load capture, stepping and offset selection per state
    always_comb begin
        hsrc_d = hsrc_q; hdst_d = hdst_q; vsrc_d = vsrc_q; vdst_d = vdst_q;
        l_d    = l_q;    k_d    = k_q;    hacc_d = hacc_q; vacc_d = vacc_q;
        hoff_d = hoff_q; voff_d = voff_q; done_d = 1'b0;
        if (ld_en) begin
            hsrc_d = ld_hsrc; hdst_d = ld_hdst;
            vsrc_d = ld_vsrc; vdst_d = ld_vdst;
            l_d    = ld_l;
        end
        case (state_q)
            S_IDLE: begin
                // Idle offsets track src, including a src arriving this cycle
                hoff_d = hsrc_d;
                voff_d = vsrc_d;
                if (start) begin
                    k_d = '0; hacc_d = '0; vacc_d = '0;
                end
            end
            S_RUN: begin
                if (tick) begin
                    k_d    = k_q + KW'(1);
                    hacc_d = hsum;
                    vacc_d = vsum;
                    done_d = last;
                    if (last) begin
                        hoff_d = hdst_q;
                        voff_d = vdst_q;
                    end else begin
                        hoff_d = hsrc_q + HWIDTH'(hstep);
                        voff_d = vsrc_q + VWIDTH'(vstep);
                    end
                end
            end
            default: begin
                if (ld_en || hold_ack) begin
                    hoff_d = hsrc_d;
                    voff_d = vsrc_d;
                end
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsrc_q <= '0; hdst_q <= '0; vsrc_q <= '0; vdst_q <= '0;
            l_q    <= '0; k_q    <= '0; hacc_q <= '0; vacc_q <= '0;
            hoff_q <= '0; voff_q <= '0; done_q <= 1'b0;
        end else begin
            hsrc_q <= hsrc_d; hdst_q <= hdst_d; vsrc_q <= vsrc_d; vdst_q <= vdst_d;
            l_q    <= l_d;    k_q    <= k_d;    hacc_q <= hacc_d; vacc_q <= vacc_d;
            hoff_q <= hoff_d; voff_q <= voff_d; done_q <= done_d;
        end
    end

    assign hoff   = hoff_q;
    assign voff   = voff_q;
    assign done   = done_q;
    assign active = (state_q == S_RUN);
endmodule

module spawn_path #(
    parameter int HWIDTH = 11,
    parameter int VWIDTH = 10,
    parameter int NCH    = 4,
    parameter int LMAX   = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spawn_path_if.slave              ld,
    input  logic [NCH-1:0]           start,
    input  logic                     tick,
    input  logic [NCH-1:0]           ack,
    output logic [NCH*HWIDTH-1:0]    hoffset,
    output logic [NCH*VWIDTH-1:0]    voffset,
    output logic [NCH-1:0]           active,
    output logic [NCH-1:0]           done
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = (LMAX > 0) ? $clog2(LMAX + 1) : 1;

    logic [LW-1:0]  l_sat;
    logic           ready_c;
    logic [NCH-1:0] ld_hit;

    // Clamp requested step count and decode which channel a load targets
    always_comb begin
        l_sat   = (int'(ld.ld_lsteps) > LMAX) ? LW'(LMAX) : ld.ld_lsteps;
        ready_c = 1'b0;
        ld_hit  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ld.ld_ch == CW'(i)) begin
                ready_c   = !active[i];
                ld_hit[i] = ld.ld_valid && !active[i];
            end
        end
    end

    assign ld.ld_ready = ready_c;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        spawn_path_ch #(.HWIDTH(HWIDTH), .VWIDTH(VWIDTH), .LMAX(LMAX), .LW(LW)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld_en   (ld_hit[g]),
            .ld_hsrc (ld.ld_hsrc),
            .ld_hdst (ld.ld_hdst),
            .ld_vsrc (ld.ld_vsrc),
            .ld_vdst (ld.ld_vdst),
            .ld_l    (l_sat),
            .start   (start[g]),
            .tick    (tick),
            .ack     (ack[g]),
            .hoff    (hoffset[g*HWIDTH +: HWIDTH]),
            .voff    (voffset[g*VWIDTH +: VWIDTH]),
            .active  (active[g]),
            .done    (done[g])
        );
    end
endmodule

// File: tb/tb_spawn_path.sv
// Self-checking bench for spawn_path: directed scenarios then random traffic,
// compared each cycle against a per-channel model that computes offsets as
// src + floor((dst-src)*n / 2^L) from the tick count n.
module tb_spawn_path;
    localparam int HW = 11, VW = 10, NCH = 4, LMAX = 7, LW = 3, CW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NCH-1:0] start = '0, ack = '0;
    logic tick = 1'b0;
    logic [NCH*HW-1:0] hoffset;
    logic [NCH*VW-1:0] voffset;
    logic [NCH-1:0] active, done;

    spawn_path_if #(.HWIDTH(HW), .VWIDTH(VW), .NCH(NCH), .LMAX(LMAX)) ldif ();

    spawn_path #(.HWIDTH(HW), .VWIDTH(VW), .NCH(NCH), .LMAX(LMAX)) dut (
        .clk(clk), .rst_n(rst_n), .ld(ldif), .start(start), .tick(tick), .ack(ack),
        .hoffset(hoffset), .voffset(voffset), .active(active), .done(done)
    );

    always #5 clk = ~clk;

    // model: mode 0 idle, 1 run, 2 hold
    int m_hs[NCH], m_hd[NCH], m_vs[NCH], m_vd[NCH], m_l[NCH], m_n[NCH], m_mode[NCH];
    int m_oh[NCH], m_ov[NCH];
    bit m_done[NCH];
    int checks = 0, errors = 0;

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_hs[i] = 0; m_hd[i] = 0; m_vs[i] = 0; m_vd[i] = 0; m_l[i] = 0;
            m_n[i] = 0; m_mode[i] = 0; m_oh[i] = 0; m_ov[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NCH*HW-1:0] eh;
        logic [NCH*VW-1:0] ev;
        logic [NCH-1:0] ea, ed;
        for (int i = 0; i < NCH; i++) begin
            eh[i*HW +: HW] = HW'(m_oh[i]);
            ev[i*VW +: VW] = VW'(m_ov[i]);
            ea[i] = (m_mode[i] == 1);
            ed[i] = m_done[i];
        end
        checks += 4;
        assert (hoffset === eh) else begin errors++; $error("FAIL %s hoffset got %h exp %h", tag, hoffset, eh); end
        assert (voffset === ev) else begin errors++; $error("FAIL %s voffset got %h exp %h", tag, voffset, ev); end
        assert (active === ea) else begin errors++; $error("FAIL %s active got %b exp %b", tag, active, ea); end
        assert (done === ed) else begin errors++; $error("FAIL %s done got %b exp %b", tag, done, ed); end
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare
    task automatic step(input bit v, input int ch, input int hs, input int hd, input int vs,
                        input int vd, input int l, input logic [NCH-1:0] st, input bit tk,
                        input logic [NCH-1:0] ak, input string tag);
        bit lacc;
        int ls;
        ldif.ld_valid = v; ldif.ld_ch = CW'(ch);
        ldif.ld_hsrc = HW'(hs); ldif.ld_hdst = HW'(hd);
        ldif.ld_vsrc = VW'(vs); ldif.ld_vdst = VW'(vd);
        ldif.ld_lsteps = LW'(l);
        start = st; tick = tk; ack = ak;
        #1;
        checks++;
        assert (ldif.ld_ready === (m_mode[ch] != 1))
        else begin errors++; $error("FAIL %s ld_ready got %b exp %b", tag, ldif.ld_ready, m_mode[ch] != 1); end
        lacc = v && (m_mode[ch] != 1) && rst_n;
        ls = (l > LMAX) ? LMAX : l;
        for (int i = 0; i < NCH; i++) begin
            bit hit;
            if (!rst_n) continue;
            hit = lacc && (ch == i);
            m_done[i] = 0;
            if (hit && m_mode[i] != 1) begin
                m_hs[i] = hs; m_hd[i] = hd; m_vs[i] = vs; m_vd[i] = vd; m_l[i] = ls;
            end
            case (m_mode[i])
                0: begin
                    m_oh[i] = m_hs[i]; m_ov[i] = m_vs[i];
                    if (st[i]) begin m_mode[i] = 1; m_n[i] = 0; end
                end
                1: if (tk) begin
                    m_n[i]++;
                    if (m_n[i] == (1 << m_l[i])) begin
                        m_oh[i] = m_hd[i]; m_ov[i] = m_vd[i]; m_done[i] = 1;
`ifdef SPAWN_HOLD_EN
                        m_mode[i] = 2;
`else
                        m_mode[i] = 0;
`endif
                    end else begin
                        m_oh[i] = m_hs[i] + fdiv((m_hd[i] - m_hs[i]) * m_n[i], 1 << m_l[i]);
                        m_ov[i] = m_vs[i] + fdiv((m_vd[i] - m_vs[i]) * m_n[i], 1 << m_l[i]);
                    end
                end
                default: if (hit || ak[i]) begin
                    m_mode[i] = 0; m_oh[i] = m_hs[i]; m_ov[i] = m_vs[i];
                end
            endcase
        end
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

    initial begin
        ldif.ld_valid = 0; ldif.ld_ch = '0; ldif.ld_hsrc = '0; ldif.ld_hdst = '0;
        ldif.ld_vsrc = '0; ldif.ld_vdst = '0; ldif.ld_lsteps = '0;
        model_reset();
        #12 check_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 4'h0, "idle");

        // 4-step path on ch0
        step(1, 0, 0, 100, 0, -40, 2, 4'h0, 0, 4'h0, "load_l2");
        step(0, 0, 0, 0, 0, 0, 0, 4'h1, 0, 4'h0, "start_l2");
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 4'h0, "tick_l2");
        checks += 3;
        assert ($signed(hoffset[0 +: HW]) === 11'sd100) else begin errors++; $error("FAIL end_h got %0d exp 100", $signed(hoffset[0 +: HW])); end
        assert ($signed(voffset[0 +: VW]) === -10'sd40) else begin errors++; $error("FAIL end_v got %0d exp -40", $signed(voffset[0 +: VW])); end
        assert (done[0] === 1'b1) else begin errors++; $error("FAIL end_done got %b exp 1", done[0]); end
        step(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 4'h0, "after_done");

        // non-divisible path, floor behaviour
        step(1, 0, 0, 7, 0, 3, 3, 4'h0, 0, 4'h0, "load_l3");
        step(0, 0, 0, 0, 0, 0, 0, 4'h1, 0, 4'h0, "start_l3");
        repeat (8) step(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 4'h0, "tick_l3");
        checks += 2;
        assert ($signed(hoffset[0 +: HW]) === 11'sd7) else begin errors++; $error("FAIL floor_h got %0d exp 7", $signed(hoffset[0 +: HW])); end
        assert ($signed(voffset[0 +: VW]) === 10'sd3) else begin errors++; $error("FAIL floor_v got %0d exp 3", $signed(voffset[0 +: VW])); end

        // ch1: start+tick same cycle, load while running is refused
        step(1, 1, 10, -20, -5, 15, 3, 4'h0, 0, 4'h0, "load_ch1");
        step(0, 1, 0, 0, 0, 0, 0, 4'h2, 1, 4'h0, "start_tick");
        step(0, 1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h0, "tick_ch1");
        step(1, 1, 300, 400, 100, 200, 1, 4'h0, 1, 4'h0, "load_busy");
        repeat (7) step(0, 1, 0, 0, 0, 0, 0, 4'h0, 1, 4'h0, "tick_ch1b");

        // asynchronous reset mid-run
        step(1, 2, 5, -50, 5, 60, 3, 4'h0, 0, 4'h0, "load_ch2");
        step(0, 2, 0, 0, 0, 0, 0, 4'h4, 0, 4'h0, "start_ch2");
        repeat (3) step(0, 2, 0, 0, 0, 0, 0, 4'h0, 1, 4'h0, "tick_ch2");
        rst_n = 1'b0;
        model_reset();
        #1 check_outputs("rst_async");
        step(0, 2, 0, 0, 0, 0, 0, 4'hF, 1, 4'h0, "rst_hold");
        step(0, 2, 0, 0, 0, 0, 0, 4'hF, 1, 4'h0, "rst_hold");
        start = '0; tick = 0; #2 rst_n = 1'b1;
        repeat (8) step(0, 2, 0, 0, 0, 0, 0, 4'h0, 1, 4'h0, "post_rst");

        // four channels, different L, overlapping ticks
        for (int c = 0; c < NCH; c++)
            step(1, c, c * 10 - 15, 200 - c * 90, 20 - c * 7, c * 33 - 60, c, 4'h0, 0, 4'h0, "load_all");
        step(0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 4'h0, "start_all");
        repeat (9) step(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 4'h1, "tick_all");

        // random traffic
        for (int r = 0; r < 600; r++) begin
            step(($urandom % 3) == 0, $urandom_range(NCH - 1),
                 int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024,
                 int'($urandom_range(1023)) - 512, int'($urandom_range(1023)) - 512,
                 $urandom_range(7), NCH'($urandom % 16) & NCH'($urandom % 16),
                 ($urandom % 2) == 1, NCH'($urandom % 16) & NCH'($urandom % 16), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
